// File: rtl/modcnt_pkg.sv
// modcnt_pkg: shared constants and helpers for the programmable mod-M counter.
//   DIR_UP / DIR_DOWN         : encoding of the 'up' direction input
//   MODE_FREERUN / MODE_ONESHOT : encoding of the 'oneshot' mode input
//   clamp_load()              : clamps a parallel-load value into [0, m-1]
package modcnt_pkg;

  localparam logic DIR_UP       = 1'b1;
  localparam logic DIR_DOWN     = 1'b0;
  localparam logic MODE_FREERUN = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

  // Helper width; callers zero-extend into it and cast the result back down,
  // so counters up to 32 bits wide are supported.
  localparam int CLAMP_W = 32;

  // A load at or beyond the modulus lands on the last legal count instead.
  function automatic logic [CLAMP_W-1:0] clamp_load(input logic [CLAMP_W-1:0] val,
                                                    input logic [CLAMP_W-1:0] m);
    logic [CLAMP_W-1:0] res;
    if (val >= m) begin
      res = m - 32'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/mod_m_counter_prog_chk.sv
// mod_m_counter_prog_chk: invariant checks for mod_m_counter_prog.
//   clk, reset : counter clock and reset
//   q, m_cur   : current count and modulus in effect
// The count must always stay below a non-zero modulus outside reset.
module mod_m_counter_prog_chk #(
  parameter int N = 16
) (
  input logic         clk,
  input logic         reset,
  input logic [N-1:0] q,
  input logic [N-1:0] m_cur
);

  a_q_below_mod: assert property (@(posedge clk) disable iff (reset)
    (q < m_cur) && (m_cur != {N{1'b0}}));

endmodule

// File: rtl/sat_counter.sv
// sat_counter: W-bit up counter that sticks at its maximum value.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset (count -> 0)
//   clear : synchronous clear, wins over inc
//   inc   : increment request
//   count : registered count value
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [W-1:0] count_r;

  // Count register: clear, saturating increment, otherwise hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (clear) begin
      count_r <= {W{1'b0}};
    end else if (inc && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/mod_m_counter_prog.sv
// mod_m_counter_prog: mod-M counter with runtime-programmable modulus.
//   clk, reset     : clock, asynchronous active-high reset
//   en, up         : count enable, direction (1 = up)
//   clr            : synchronous restart (also clears done/wraps)
//   ld, ld_val     : synchronous parallel load, clamped below the modulus
//   mod_we, mod_in : stage a new modulus (0 is ignored)
//   oneshot        : 1 = stop at terminal count, 0 = wrap
//   q, m_cur       : current count, modulus in effect
//   tick           : terminal event this cycle (combinational)
//   done, wraps    : one-shot finished flag, saturating tick count
module mod_m_counter_prog
  import modcnt_pkg::*;
#(
  parameter int N = 16,
  parameter int M = 10,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         ld,
  input  logic [N-1:0] ld_val,
  input  logic         mod_we,
  input  logic [N-1:0] mod_in,
  input  logic         oneshot,
  output logic [N-1:0] q,
  output logic [N-1:0] m_cur,
  output logic         tick,
  output logic         done,
  output logic [W-1:0] wraps
);

  localparam logic [N-1:0] ZERO  = {N{1'b0}};
  localparam logic [N-1:0] ONE   = N'(1);
  localparam logic [N-1:0] M_RST = N'(M);

  logic [N-1:0] q_r, q_s;
  logic [N-1:0] m_cur_r, m_cur_s;
  logic [N-1:0] pending_r, pending_s;
  logic         pend_valid_r, pend_valid_s;
  logic         done_r, done_s;

  logic [N-1:0] m_new_s;
  logic [N-1:0] restart_s;
  logic [N-1:0] ld_clamp_s;
  logic         term_s;
  logic         tick_s;
  logic         mod_ok_s;
  logic         apply_s;

  // Terminal detection, tick and the modulus that a restart would use.
  always_comb begin
    m_new_s    = pend_valid_r ? pending_r : m_cur_r;
    restart_s  = (up == DIR_UP) ? ZERO : (m_new_s - ONE);
    ld_clamp_s = N'(clamp_load(32'(ld_val), 32'(m_cur_r)));
    if (up == DIR_DOWN) begin
      term_s = (q_r == ZERO);
    end else begin
      term_s = (q_r == (m_cur_r - ONE));
    end
    tick_s   = en & term_s & ~clr & ~ld & ~done_r;
    mod_ok_s = mod_we & (mod_in != ZERO);
    // Staged modulus is consumed only at a restart or a free-run wrap.
    apply_s  = clr | (tick_s & (oneshot == MODE_FREERUN));
  end

  // Next-state for count, modulus in effect and one-shot flag.
  always_comb begin
    q_s     = q_r;
    m_cur_s = m_cur_r;
    done_s  = done_r;
    if (clr) begin
      q_s     = restart_s;
      m_cur_s = m_new_s;
      done_s  = 1'b0;
    end else if (ld) begin
      q_s    = ld_clamp_s;
      done_s = 1'b0;
    end else if (tick_s) begin
      if (oneshot == MODE_ONESHOT) begin
        done_s = 1'b1;
      end else begin
        q_s     = restart_s;
        m_cur_s = m_new_s;
      end
    end else if (en && !done_r && !term_s) begin
      q_s = (up == DIR_UP) ? (q_r + ONE) : (q_r - ONE);
    end else begin
      q_s = q_r;
    end
  end

  // Next-state for the staged modulus; a write on an apply cycle is kept for the next one.
  always_comb begin
    pending_s    = pending_r;
    pend_valid_s = pend_valid_r;
    if (apply_s) begin
      pend_valid_s = mod_ok_s;
      pending_s    = mod_ok_s ? mod_in : pending_r;
    end else if (mod_ok_s) begin
      pend_valid_s = 1'b1;
      pending_s    = mod_in;
    end else begin
      pend_valid_s = pend_valid_r;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r          <= ZERO;
      m_cur_r      <= M_RST;
      pending_r    <= M_RST;
      pend_valid_r <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      q_r          <= q_s;
      m_cur_r      <= m_cur_s;
      pending_r    <= pending_s;
      pend_valid_r <= pend_valid_s;
      done_r       <= done_s;
    end
  end

  sat_counter #(.W(W)) u_wraps (
    .clk   (clk),
    .reset (reset),
    .clear (clr),
    .inc   (tick_s),
    .count (wraps)
  );

  mod_m_counter_prog_chk #(.N(N)) u_chk (
    .clk   (clk),
    .reset (reset),
    .q     (q_r),
    .m_cur (m_cur_r)
  );

  assign q     = q_r;
  assign m_cur = m_cur_r;
  assign tick  = tick_s;
  assign done  = done_r;

endmodule

// File: tb/tb_mod_m_counter_prog.sv
// Testbench for mod_m_counter_prog: directed plan followed by random stimulus,
// two instances (M=10/W=8 and M=1/W=2) driven by the same inputs and checked
// every cycle against an arithmetic reference model.
module tb_mod_m_counter_prog;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, up, clr, ld, mod_we, oneshot;
  logic [15:0] ld_val, mod_in;

  logic [15:0] q1, m1, q2, m2;
  logic        tick1, done1, tick2, done2;
  logic [7:0]  wraps1;
  logic [1:0]  wraps2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_m_counter_prog #(.N(16), .M(10), .W(8)) dut1 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .mod_we(mod_we), .mod_in(mod_in), .oneshot(oneshot),
    .q(q1), .m_cur(m1), .tick(tick1), .done(done1), .wraps(wraps1)
  );

  mod_m_counter_prog #(.N(16), .M(1), .W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en), .up(up), .clr(clr), .ld(ld),
    .ld_val(ld_val), .mod_we(mod_we), .mod_in(mod_in), .oneshot(oneshot),
    .q(q2), .m_cur(m2), .tick(tick2), .done(done2), .wraps(wraps2)
  );

  // Reference model state: count, modulus, staged modulus, flags, wraps.
  typedef struct packed {
    logic [31:0] q;
    logic [31:0] m;
    logic [31:0] pend;
    logic        pv;
    logic        done;
    logic [31:0] wraps;
  } mst_t;

  mst_t s1, s2;

  function automatic mst_t mreset(input logic [31:0] m);
    mst_t r;
    r.q = 32'd0; r.m = m; r.pend = m; r.pv = 1'b0; r.done = 1'b0; r.wraps = 32'd0;
    return r;
  endfunction

  function automatic logic mtick(input mst_t s, input logic e, input logic u,
                                 input logic c, input logic l);
    logic at_end;
    at_end = u ? (s.q == s.m - 32'd1) : (s.q == 32'd0);
    return e && at_end && !c && !l && !s.done;
  endfunction

  function automatic mst_t mstep(input mst_t s, input logic e, input logic u,
                                 input logic c, input logic l, input logic [31:0] lv,
                                 input logic we, input logic [31:0] mi,
                                 input logic os, input logic [31:0] wmax);
    mst_t n;
    logic t;
    logic [31:0] mnew;
    n = s;
    t = mtick(s, e, u, c, l);
    mnew = s.pv ? s.pend : s.m;
    if (c) begin
      n.q = u ? 32'd0 : mnew - 32'd1;
      n.m = mnew; n.pv = 1'b0; n.done = 1'b0; n.wraps = 32'd0;
    end else if (l) begin
      n.q = (lv >= s.m) ? s.m - 32'd1 : lv;
      n.done = 1'b0;
    end else if (t && os) begin
      n.done = 1'b1;
    end else if (t) begin
      n.q = u ? 32'd0 : mnew - 32'd1;
      n.m = mnew; n.pv = 1'b0;
    end else if (e && !s.done) begin
      n.q = u ? s.q + 32'd1 : s.q - 32'd1;
    end
    if (t && (n.wraps < wmax)) n.wraps = n.wraps + 32'd1;
    if (we && (mi != 32'd0)) begin
      n.pend = mi; n.pv = 1'b1;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic e, input logic u, input logic c, input logic l,
                       input logic [15:0] lv, input logic we, input logic [15:0] mi,
                       input logic os);
    en = e; up = u; clr = c; ld = l; ld_val = lv; mod_we = we; mod_in = mi; oneshot = os;
  endtask

  // Compare both instances at the falling edge, then advance the model across the rising edge.
  task automatic step();
    @(negedge clk);
    chk("q1", 32'(q1), s1.q);
    chk("m1", 32'(m1), s1.m);
    chk("tick1", 32'(tick1), 32'(mtick(s1, en, up, clr, ld)));
    chk("done1", 32'(done1), 32'(s1.done));
    chk("wraps1", 32'(wraps1), s1.wraps);
    chk("q2", 32'(q2), s2.q);
    chk("m2", 32'(m2), s2.m);
    chk("tick2", 32'(tick2), 32'(mtick(s2, en, up, clr, ld)));
    chk("done2", 32'(done2), 32'(s2.done));
    chk("wraps2", 32'(wraps2), s2.wraps);
    s1 = mstep(s1, en, up, clr, ld, 32'(ld_val), mod_we, 32'(mod_in), oneshot, 32'd255);
    s2 = mstep(s2, en, up, clr, ld, 32'(ld_val), mod_we, 32'(mod_in), oneshot, 32'd3);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    s1 = mreset(32'd10);
    s2 = mreset(32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", 32'(q1), 32'd0);
    chk("rst_m", 32'(m1), 32'd10);
    chk("rst_tick", 32'(tick1), 32'd0);
    chk("rst_done", 32'(done1), 32'd0);
    chk("rst_wraps", 32'(wraps1), 32'd0);
    chk("rst_m2", 32'(m2), 32'd1);
    reset = 1'b0;

    // Free-run up count, modulus 10 (dut2 ticks every cycle and saturates).
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    for (int k = 0; k < 25; k++) begin
      #3;
      chk("p1_q", 32'(q1), 32'(k % 10));
      chk("p1_tick", 32'(tick1), 32'((k == 9) || (k == 19)));
      chk("p1_tick2", 32'(tick2), 32'd1);
      step();
    end
    chk("p1_wraps", 32'(wraps1), 32'd2);
    chk("p1_wraps2_sat", 32'(wraps2), 32'd3);

    // Stage modulus 4 mid-period; it applies on the wrap only.
    repeat (8) step();
    chk("p2_q3", 32'(q1), 32'd3);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 16'd4, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    repeat (5) begin
      chk("p2_m_hold", 32'(m1), 32'd10);
      step();
    end
    #3;
    chk("p2_q9", 32'(q1), 32'd9);
    chk("p2_tick9", 32'(tick1), 32'd1);
    step();
    chk("p2_m4", 32'(m1), 32'd4);
    for (int i = 0; i < 8; i++) begin
      chk("p2_q_mod4", 32'(q1), 32'(i % 4));
      step();
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 16'd0, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    repeat (8) step();
    chk("p2_m_zero_ignored", 32'(m1), 32'd4);

    // One-shot down count from a restart at modulus 10.
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b1, 16'd10, 1'b0);
    step();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    step();
    chk("p3_q9", 32'(q1), 32'd9);
    chk("p3_m10", 32'(m1), 32'd10);
    chk("p3_done0", 32'(done1), 32'd0);
    chk("p3_wraps2_clr", 32'(wraps2), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      #3;
      chk("p3_q_down", 32'(q1), 32'(9 - i));
      chk("p3_tick", 32'(tick1), 32'(i == 9));
      step();
    end
    chk("p3_done1", 32'(done1), 32'd1);
    repeat (5) begin
      #3;
      chk("p3_hold_tick", 32'(tick1), 32'd0);
      step();
    end
    chk("p3_hold_q", 32'(q1), 32'd0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 16'd0, 1'b1);
    step();
    chk("p3_restart_q", 32'(q1), 32'd9);
    chk("p3_restart_done", 32'(done1), 32'd0);

    // Load clamp, clr over ld, enable gating.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 16'd15, 1'b0, 16'd0, 1'b0);
    step();
    chk("p4_ld_clamp", 32'(q1), 32'd9);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 16'd5, 1'b0, 16'd0, 1'b0);
    step();
    chk("p4_clr_wins", 32'(q1), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 16'd0, 1'b0);
    step();
    chk("p4_en1", 32'(q1), 32'd1);
    en = 1'b0;
    step();
    chk("p4_en0", 32'(q1), 32'd1);
    en = 1'b1;
    step();
    chk("p4_en1b", 32'(q1), 32'd2);

    // Asynchronous reset between edges.
    repeat (4) step();
    chk("p5_q6", 32'(q1), 32'd6);
    #1 reset = 1'b1;
    #1;
    chk("p5_async_q", 32'(q1), 32'd0);
    chk("p5_async_done", 32'(done1), 32'd0);
    chk("p5_async_wraps", 32'(wraps1), 32'd0);
    chk("p5_async_m", 32'(m1), 32'd10);
    chk("p5_async_m2", 32'(m2), 32'd1);
    s1 = mreset(32'd10);
    s2 = mreset(32'd1);
    #1 reset = 1'b0;
    repeat (3) step();
    chk("p5_resume", 32'(q1), 32'd3);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom_range(0, 9) < 8);
      up      = ($urandom_range(0, 19) == 0) ? ~up : up;
      clr     = ($urandom_range(0, 39) == 0);
      ld      = ($urandom_range(0, 29) == 0);
      ld_val  = 16'($urandom_range(0, 25));
      mod_we  = ($urandom_range(0, 14) == 0);
      mod_in  = 16'($urandom_range(0, 12));
      oneshot = ($urandom_range(0, 49) == 0) ? ~oneshot : oneshot;
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
